// File: rtl/daq_sampler_pkg.sv
// Shared DAQ packet layout: field positions of word 0 and the sampler FSM
// state encoding. The field constants are common to daq and the host decoder.
// Ports: none (package).
package daq_sampler_pkg;

  localparam int DAQ_TAG_MSB   = 31;
  localparam int DAQ_TAG_LSB   = 24;
  localparam int DAQ_DROP_BIT  = 23;
  localparam int DAQ_PAYLOAD_W = 18;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_W0   = 2'd2,
    ST_W1   = 2'd3
  } daq_state_t;

  // Word 0 = {tag[7:0], drop flag, 5'b0, payload[17:0]}
  function automatic logic [31:0] daq_word0(input logic [7:0]               tag,
                                            input logic                     drop,
                                            input logic [DAQ_PAYLOAD_W-1:0] payload);
    daq_word0 = {tag, drop, 5'b00000, payload};
  endfunction

endpackage

// File: rtl/daq_sampler_sync_fifo.sv
// Synchronous FIFO with full/empty flags, show-ahead read data (head of queue
// is always visible on o_rdata). Pointers carry one extra wrap bit.
// Ports: clk/rst_n, i_push/i_wdata write side, i_pop/o_rdata read side, o_full, o_empty.
module sync_fifo #(
  parameter int WIDTH      = 51,
  parameter int DEPTH_BITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam logic [DEPTH_BITS:0] PTR_ONE = 1;

  logic [WIDTH-1:0]    r_mem [2**DEPTH_BITS];
  logic [DEPTH_BITS:0] r_wptr;
  logic [DEPTH_BITS:0] r_rptr;
  logic                w_do_push;
  logic                w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[DEPTH_BITS] != r_rptr[DEPTH_BITS]) &&
                     (r_wptr[DEPTH_BITS-1:0] == r_rptr[DEPTH_BITS-1:0]);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_rdata   = r_mem[r_rptr[DEPTH_BITS-1:0]];

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr[DEPTH_BITS-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/daq_sampler.sv
// Periodic sampler: strobes every max(period,1) cycles while enabled, queues
// {systime, signal, pending_drop} records and sends each as a 2-word DAQ packet.
// Ports: clk/rst_n, systime, signal, enable, period in; daq_data/valid/end/req out,
//        daq_grant in, drop_count out (saturating count of samples lost to a full FIFO).
module daq_sampler
  import daq_sampler_pkg::*;
#(
  parameter int CHANNEL     = 0,
  parameter int SIG_WIDTH   = 18,
  parameter int DEPTH_BITS  = 4,
  parameter int PERIOD_BITS = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            systime,
  input  logic [SIG_WIDTH-1:0]   signal,
  input  logic                   enable,
  input  logic [PERIOD_BITS-1:0] period,
  output logic [31:0]            daq_data,
  output logic                   daq_valid,
  output logic                   daq_end,
  output logic                   daq_req,
  input  logic                   daq_grant,
  output logic [15:0]            drop_count
);

  localparam int                     REC_W   = 32 + SIG_WIDTH + 1;
  localparam logic [7:0]             TAG     = 8'(CHANNEL);
  localparam logic [PERIOD_BITS-1:0] CNT_ONE = 1;

  // Interval counter
  logic                   r_en_d;
  logic [PERIOD_BITS-1:0] r_cnt;
  logic [PERIOD_BITS-1:0] w_load_val;
  logic                   w_rise;
  logic                   w_strobe;

  // Record queue
  logic             r_pend;
  logic [15:0]      r_drop;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic [REC_W-1:0] w_wdata;
  logic [REC_W-1:0] w_rdata;

  // Packet FSM
  daq_state_t r_state;
  daq_state_t w_nstate;
  logic       w_nvalid;
  logic       w_nend;
  logic       w_nreq;
  logic [31:0] w_ndata;
  logic [31:0] r_data;
  logic        r_valid;
  logic        r_end;
  logic        r_req;
  logic [31:0]              w_head_ts;
  logic [SIG_WIDTH-1:0]     w_head_sig;
  logic                     w_head_drop;
  logic [DAQ_PAYLOAD_W-1:0] w_payload;
  logic [31:0]              w_word0;

  // period==0 behaves as 1, so the reload value never underflows.
  assign w_load_val = (period == '0) ? '0 : (period - CNT_ONE);
  assign w_rise     = enable & ~r_en_d;
  // The rising cycle only loads; strobes start counting from the next cycle.
  assign w_strobe   = enable & r_en_d & (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_d <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_en_d <= enable;
      if (w_rise || w_strobe) begin
        r_cnt <= w_load_val;
      end else if (enable) begin
        r_cnt <= r_cnt - CNT_ONE;
      end
    end
  end

  // A strobe with the FIFO full loses the sample; the next stored record
  // carries the drop flag so the host sees the gap.
  assign w_push  = w_strobe & ~w_full;
  assign w_wdata = {systime, signal, r_pend};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 1'b0;
      r_drop <= '0;
    end else if (w_strobe) begin
      r_pend <= w_full;
      if (w_full && (r_drop != 16'hFFFF)) begin
        r_drop <= r_drop + 16'd1;
      end
    end
  end

  sync_fifo #(
    .WIDTH      (REC_W),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head_ts   = w_rdata[REC_W-1 -: 32];
  assign w_head_sig  = w_rdata[SIG_WIDTH:1];
  assign w_head_drop = w_rdata[0];

  always_comb begin
    w_payload                = '0;
    w_payload[SIG_WIDTH-1:0] = w_head_sig;
  end

  assign w_word0 = daq_word0(TAG, w_head_drop, w_payload);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_end   <= 1'b0;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_data  <= w_ndata;
      r_valid <= w_nvalid;
      r_end   <= w_nend;
      r_req   <= w_nreq;
    end
  end

  // Outputs are registered from the next state, so r_valid marks a word that
  // the arbiter sees this cycle. In W0/W1 a word only advances once it was
  // actually presented; otherwise the state stalls and valid follows grant.
  always_comb begin
    w_nstate = r_state;
    w_nvalid = 1'b0;
    w_pop    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) w_nstate = ST_REQ;
      end
      ST_REQ: begin
        if (daq_grant) begin
          w_nstate = ST_W0;
          w_nvalid = 1'b1;
        end
      end
      ST_W0: begin
        if (r_valid) w_nstate = ST_W1;
        w_nvalid = daq_grant;
      end
      ST_W1: begin
        if (r_valid) begin
          w_nstate = ST_IDLE;
          w_pop    = 1'b1;
        end else begin
          w_nvalid = daq_grant;
        end
      end
      default: w_nstate = ST_IDLE;
    endcase

    w_nreq  = (w_nstate != ST_IDLE);
    w_nend  = w_nvalid && (w_nstate == ST_W1);
    w_ndata = '0;
    if (w_nstate == ST_W0)      w_ndata = w_word0;
    else if (w_nstate == ST_W1) w_ndata = w_head_ts;
  end

  assign daq_data   = r_data;
  assign daq_valid  = r_valid;
  assign daq_end    = r_end;
  assign daq_req    = r_req;
  assign drop_count = r_drop;

endmodule
